rx_framer: RTL and testbench

//  Serial receive framer downstream of the flex_counter bit timer.
//  - Drives the timer's clear and count_enable inputs.
//  - Consumes the timer's rollover_flag as a one-cycle mid-bit sample strobe.
//  - Detects the start bit, shifts in data LSB-first and checks the stop bit.
//  - Presents each byte through a ready/read handshake with error flags.

---
 rtl/rx_framer.sv | 164 ++++++++++++++++
 tb/tb_rx_framer.sv | 245 ++++++++++++++++++++++++
 2 files changed

// File: rtl/rx_framer.sv
`default_nettype none
// ============================================================================
// Module      : rx_framer
// Description : Serial receive framer driven by an external bit timer; start
//               detect, LSB-first shift-in, stop check, ready/read handoff.
//               Optional even-parity stage enabled by RX_FRAMER_PARITY_EN.
// Revision    : 1.0 - initial release
// ============================================================================
module rx_framer #(
    parameter int DATA_BITS = 8
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 serial_in,
    input  logic                 sample_tick,
    input  logic                 data_read,
    output logic                 timer_clear,
    output logic                 timer_enable,
    output logic [DATA_BITS-1:0] rx_data,
    output logic                 data_ready,
    output logic                 overrun_error,
    output logic                 framing_error,
`ifdef RX_FRAMER_PARITY_EN
    output logic                 parity_error,
`endif
    output logic                 busy
);

    localparam int c_CNT_W = (DATA_BITS > 1) ? $clog2(DATA_BITS) : 1;
    localparam logic [c_CNT_W-1:0] c_LAST_BIT = c_CNT_W'(DATA_BITS - 1);

    localparam logic [2:0] c_ST_IDLE   = 3'd0;
    localparam logic [2:0] c_ST_START  = 3'd1;
    localparam logic [2:0] c_ST_RECV   = 3'd2;
`ifdef RX_FRAMER_PARITY_EN
    localparam logic [2:0] c_ST_PARITY = 3'd3;
`endif
    localparam logic [2:0] c_ST_STOP   = 3'd4;
    localparam logic [2:0] c_ST_LOAD   = 3'd5;

    logic [2:0]           r_state;
    logic [c_CNT_W-1:0]   r_bitcnt;
    logic [DATA_BITS-1:0] r_shift;
    logic [DATA_BITS-1:0] r_rx_data;
    logic                 r_s1, r_s2, r_s3;
    logic                 r_data_ready;
    logic                 r_overrun;
    logic                 r_framing;
`ifdef RX_FRAMER_PARITY_EN
    logic                 r_parity;
`endif
    logic                 w_fall;

    assign w_fall = r_s3 & ~r_s2;

    // Clear is Mealy so the timer restarts on the very edge that enters START.
    assign timer_clear   = (r_state == c_ST_IDLE) && w_fall;
    assign timer_enable  = (r_state != c_ST_IDLE) && (r_state != c_ST_LOAD);
    assign busy          = (r_state != c_ST_IDLE);
    assign rx_data       = r_rx_data;
    assign data_ready    = r_data_ready;
    assign overrun_error = r_overrun;
    assign framing_error = r_framing;
`ifdef RX_FRAMER_PARITY_EN
    assign parity_error  = r_parity;
`endif

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state      <= c_ST_IDLE;
            r_bitcnt     <= '0;
            r_shift      <= '0;
            r_rx_data    <= '0;
            r_s1         <= 1'b1;
            r_s2         <= 1'b1;
            r_s3         <= 1'b1;
            r_data_ready <= 1'b0;
            r_overrun    <= 1'b0;
            r_framing    <= 1'b0;
`ifdef RX_FRAMER_PARITY_EN
            r_parity     <= 1'b0;
`endif
        end else begin
            r_s1 <= serial_in;
            r_s2 <= r_s1;
            r_s3 <= r_s2;

            // Consumer handoff; a LOAD in the same cycle overrides below.
            if (r_data_ready && data_read) begin
                r_data_ready <= 1'b0;
                r_overrun    <= 1'b0;
            end

            case (r_state)
                c_ST_IDLE: begin
                    if (w_fall) begin
                        r_state   <= c_ST_START;
                        r_framing <= 1'b0;
`ifdef RX_FRAMER_PARITY_EN
                        r_parity  <= 1'b0;
`endif
                    end
                end
                c_ST_START: begin
                    if (sample_tick) begin
                        if (!r_s2) begin
                            r_state  <= c_ST_RECV;
                            r_bitcnt <= '0;
                        end else begin
                            r_state  <= c_ST_IDLE;
                        end
                    end
                end
                c_ST_RECV: begin
                    if (sample_tick) begin
                        r_shift  <= {r_s2, r_shift[DATA_BITS-1:1]};
                        r_bitcnt <= r_bitcnt + 1'b1;
                        if (r_bitcnt == c_LAST_BIT) begin
`ifdef RX_FRAMER_PARITY_EN
                            r_state <= c_ST_PARITY;
`else
                            r_state <= c_ST_STOP;
`endif
                        end
                    end
                end
`ifdef RX_FRAMER_PARITY_EN
                c_ST_PARITY: begin
                    if (sample_tick) begin
                        // Even parity: the parity bit equals the XOR of the payload.
                        if (r_s2 != ^r_shift) begin
                            r_parity <= 1'b1;
                        end
                        r_state <= c_ST_STOP;
                    end
                end
`endif
                c_ST_STOP: begin
                    if (sample_tick) begin
                        if (r_s2) begin
                            r_state   <= c_ST_LOAD;
                        end else begin
                            r_framing <= 1'b1;
                            r_state   <= c_ST_IDLE;
                        end
                    end
                end
                c_ST_LOAD: begin
                    r_rx_data    <= r_shift;
                    r_data_ready <= 1'b1;
                    if (r_data_ready && !data_read) begin
                        r_overrun <= 1'b1;
                    end
                    r_state <= c_ST_IDLE;
                end
                default: begin
                    r_state <= c_ST_IDLE;
                end
            endcase
        end
    end

endmodule
`default_nettype wire

// File: tb/tb_rx_framer.sv
`default_nettype none
// ============================================================================
// Module      : tb_rx_framer
// Description : Self-checking bench for rx_framer: frame table + scoreboard,
//               plus reset, false-start and mid-frame reset sequences.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_rx_framer;

    localparam int c_DATA_BITS = 8;

    logic                   tb_clk = 1'b0;
    logic                   rst = 1'b1;
    logic                   serial_in = 1'b1;
    logic                   sample_tick = 1'b0;
    logic                   data_read = 1'b0;
    logic                   timer_clear;
    logic                   timer_enable;
    logic [c_DATA_BITS-1:0] rx_data;
    logic                   data_ready;
    logic                   overrun_error;
    logic                   framing_error;
`ifdef RX_FRAMER_PARITY_EN
    logic                   parity_error;
`endif
    logic                   busy;

    int tests  = 0;
    int fails  = 0;
    int clr_cnt = 0;

    rx_framer #(.DATA_BITS(c_DATA_BITS)) dut (
        .clk           (tb_clk),
        .rst           (rst),
        .serial_in     (serial_in),
        .sample_tick   (sample_tick),
        .data_read     (data_read),
        .timer_clear   (timer_clear),
        .timer_enable  (timer_enable),
        .rx_data       (rx_data),
        .data_ready    (data_ready),
        .overrun_error (overrun_error),
        .framing_error (framing_error),
`ifdef RX_FRAMER_PARITY_EN
        .parity_error  (parity_error),
`endif
        .busy          (busy)
    );

    always #5 tb_clk = ~tb_clk;

    always @(posedge tb_clk) begin
        if (timer_clear) clr_cnt <= clr_cnt + 1;
    end

    typedef struct {
        logic [7:0] data;
        logic       stop;
        logic       rd;
        logic [7:0] exp_rx;
        logic       exp_ready;
        logic       exp_ovr;
        logic       exp_fe;
    } vec_t;

    typedef struct {
        logic [7:0] rx;
        logic       ready;
        logic       ovr;
        logic       fe;
    } exp_t;

    vec_t vecs[5];
    exp_t sbq[$];

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic step(input int n);
        repeat (n) begin
            @(posedge tb_clk);
            #1;
        end
    endtask

    // One bit period is 16 clocks with the sample tick at clock 8.
    task automatic send_bit(input logic b);
        serial_in = b;
        step(8);
        sample_tick = 1'b1;
        step(1);
        sample_tick = 1'b0;
        step(7);
    endtask

    task automatic send_frame(input logic [7:0] d, input logic stop, input logic par_bad,
                              input logic chk_lat);
        send_bit(1'b0);
        for (int i = 0; i < c_DATA_BITS; i++) send_bit(d[i]);
`ifdef RX_FRAMER_PARITY_EN
        send_bit((^d) ^ par_bad);
`endif
        if (chk_lat) begin
            serial_in = stop;
            step(8);
            sample_tick = 1'b1;
            step(1);
            sample_tick = 1'b0;
            check("lat_edge1_ready", data_ready, 1'b0);
            check("lat_edge1_busy", busy, 1'b1);
            step(1);
            check("lat_edge2_ready", data_ready, 1'b1);
            check("lat_edge2_busy", busy, 1'b0);
            step(6);
        end else begin
            send_bit(stop);
        end
        serial_in = 1'b1;
        step(4);
    endtask

    task automatic do_read();
        data_read = 1'b1;
        step(1);
        data_read = 1'b0;
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog expired");
    end

    initial begin
        exp_t e;
        vecs[0] = '{8'hA5, 1'b1, 1'b1, 8'hA5, 1'b1, 1'b0, 1'b0};
        vecs[1] = '{8'h5A, 1'b0, 1'b0, 8'hA5, 1'b0, 1'b0, 1'b1};
        vecs[2] = '{8'h3C, 1'b1, 1'b0, 8'h3C, 1'b1, 1'b0, 1'b0};
        vecs[3] = '{8'hC3, 1'b1, 1'b1, 8'hC3, 1'b1, 1'b1, 1'b0};
        vecs[4] = '{8'h81, 1'b1, 1'b1, 8'h81, 1'b1, 1'b0, 1'b0};

        // Reset state and idle behaviour
        rst = 1'b1;
        step(2);
        check("rst_rx_data", rx_data, 8'h00);
        check("rst_ready", data_ready, 1'b0);
        check("rst_overrun", overrun_error, 1'b0);
        check("rst_framing", framing_error, 1'b0);
        check("rst_busy", busy, 1'b0);
        check("rst_timer_clear", timer_clear, 1'b0);
`ifdef RX_FRAMER_PARITY_EN
        check("rst_parity", parity_error, 1'b0);
`endif
        rst = 1'b0;
        for (int i = 0; i < 10; i++) begin
            check("idle_timer_enable", timer_enable, 1'b0);
            step(1);
        end
        sample_tick = 1'b1;
        step(1);
        sample_tick = 1'b0;
        check("idle_tick_busy", busy, 1'b0);

        // Table-driven frames with scoreboard
        for (int i = 0; i < 5; i++) begin
            sbq.push_back('{vecs[i].exp_rx, vecs[i].exp_ready, vecs[i].exp_ovr, vecs[i].exp_fe});
            clr_cnt = 0;
            send_frame(vecs[i].data, vecs[i].stop, 1'b0, i == 0);
            e = sbq.pop_front();
            check("frame_clear_pulses", clr_cnt, 1);
            check("frame_rx_data", rx_data, e.rx);
            check("frame_ready", data_ready, e.ready);
            check("frame_overrun", overrun_error, e.ovr);
            check("frame_framing", framing_error, e.fe);
            check("frame_busy", busy, 1'b0);
`ifdef RX_FRAMER_PARITY_EN
            check("frame_parity", parity_error, 1'b0);
`endif
            if (vecs[i].rd) begin
                do_read();
                check("read_ready", data_ready, 1'b0);
                check("read_overrun", overrun_error, 1'b0);
            end
        end

        // False start: line low 3 clocks, back high before the first tick
        clr_cnt = 0;
        serial_in = 1'b0;
        step(3);
        serial_in = 1'b1;
        step(5);
        check("fstart_busy_before", busy, 1'b1);
        sample_tick = 1'b1;
        step(1);
        sample_tick = 1'b0;
        check("fstart_busy_after", busy, 1'b0);
        check("fstart_ready", data_ready, 1'b0);
        check("fstart_framing", framing_error, 1'b0);
        check("fstart_clear_pulses", clr_cnt, 1);
        step(8);

        // Reset in the middle of RECV after 4 bits
        send_bit(1'b0);
        for (int i = 0; i < 4; i++) send_bit(1'b1);
        check("midrst_busy_before", busy, 1'b1);
        serial_in = 1'b1;
        rst = 1'b1;
        step(1);
        rst = 1'b0;
        check("midrst_busy", busy, 1'b0);
        check("midrst_rx_data", rx_data, 8'h00);
        check("midrst_ready", data_ready, 1'b0);
        check("midrst_timer_enable", timer_enable, 1'b0);
        step(4);
        sbq.push_back('{8'h81, 1'b1, 1'b0, 1'b0});
        send_frame(8'h81, 1'b1, 1'b0, 1'b0);
        e = sbq.pop_front();
        check("post_rst_rx_data", rx_data, e.rx);
        check("post_rst_ready", data_ready, e.ready);
        check("post_rst_overrun", overrun_error, e.ovr);
        do_read();

`ifdef RX_FRAMER_PARITY_EN
        // Wrong parity still loads the frame but flags it
        send_frame(8'h81, 1'b1, 1'b1, 1'b0);
        check("par_bad_flag", parity_error, 1'b1);
        check("par_bad_rx_data", rx_data, 8'h81);
        check("par_bad_ready", data_ready, 1'b1);
        do_read();
        send_frame(8'h7E, 1'b1, 1'b0, 1'b0);
        check("par_clear_flag", parity_error, 1'b0);
        check("par_clear_rx_data", rx_data, 8'h7E);
`endif

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
`default_nettype wire
